// File: rtl/burst_mem_responder_if.sv
// Burst-memory bus between mem_arbiter (master) and the backing responder (slave).
// Carries line read/write requests, write beats, read-return beats and the protocol-error flag.
interface burst_mem_responder_if;
    logic        bmem_read;
    logic        bmem_write;
    logic [31:0] bmem_addr;
    logic [63:0] bmem_wdata;
    logic        bmem_ready;
    logic        bmem_rvalid;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        proto_err;

    modport master (
        output bmem_read, bmem_write, bmem_addr, bmem_wdata,
        input  bmem_ready, bmem_rvalid, bmem_raddr, bmem_rdata, proto_err
    );

    modport slave (
        input  bmem_read, bmem_write, bmem_addr, bmem_wdata,
        output bmem_ready, bmem_rvalid, bmem_raddr, bmem_rdata, proto_err
    );
endinterface

// File: rtl/burst_mem_responder.sv
// Backing line store for the bmem burst protocol: 4-beat line writes, snapshot-on-accept
// read queue and a fixed-latency engine returning 4x64-bit read bursts.
module burst_mem_responder #(
    parameter int LINES        = 256,
    parameter int QUEUE_DEPTH  = 4,
    parameter int READ_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    burst_mem_responder_if.slave  bus
);
    localparam int IDX_W = $clog2(LINES);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(READ_LATENCY);
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(QUEUE_DEPTH);
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(READ_LATENCY - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

    typedef logic [3:0][63:0] line_t;

    line_t            mem_q       [LINES];
    logic [26:0]      ent_addr_q  [QUEUE_DEPTH];
    line_t            ent_data_q  [QUEUE_DEPTH];
    logic [CNT_W-1:0] ent_cnt_q   [QUEUE_DEPTH];

    logic [0:0]       state_q,  state_d;
    logic [1:0]       wbeat_q,  wbeat_d;
    logic [IDX_W-1:0] widx_q,   widx_d;
    logic             err_q,    err_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             burst_q,  burst_d;
    logic [1:0]       beat_q,   beat_d;
    logic             ready_q,  ready_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      raddr_q,  raddr_d;
    logic [63:0]      rdata_q,  rdata_d;

    logic             mem_we;
    logic [IDX_W-1:0] mem_widx;
    logic [1:0]       mem_wbeat;
    logic             push, pop, head_due;
    logic [IDX_W-1:0] addr_idx;
    logic             unused_addr_lsbs;

    assign addr_idx         = bus.bmem_addr[5 +: IDX_W];
    assign unused_addr_lsbs = ^bus.bmem_addr[4:0];

    // Head is due when this cycle's decrement would bring its countdown to zero.
    assign head_due = (count_q != '0) && (ent_cnt_q[rd_ptr_q] <= CNT_W'(1));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        wbeat_d   = wbeat_q;
        widx_d    = widx_q;
        err_d     = err_q | (bus.bmem_read & bus.bmem_write);
        mem_we    = 1'b0;
        mem_widx  = widx_q;
        mem_wbeat = wbeat_q;
        push      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ready_q && bus.bmem_write) begin
                    mem_we    = 1'b1;
                    mem_widx  = addr_idx;
                    mem_wbeat = 2'd0;
                    widx_d    = addr_idx;
                    wbeat_d   = 2'd1;
                    state_d   = ST_WRITE;
                end else if (ready_q && bus.bmem_read) begin
                    push = 1'b1;
                end
            end
            ST_WRITE: begin
                if (bus.bmem_write) begin
                    mem_we  = 1'b1;
                    wbeat_d = wbeat_q + 2'd1;
                    if (wbeat_q == 2'd3) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rvalid_d = 1'b0;
        raddr_d  = raddr_q;
        rdata_d  = rdata_q;
        burst_d  = burst_q;
        beat_d   = beat_q;
        pop      = 1'b0;
        if (burst_q) begin
            rvalid_d = 1'b1;
            raddr_d  = {ent_addr_q[rd_ptr_q], 5'b0};
            rdata_d  = ent_data_q[rd_ptr_q][beat_q];
            beat_d   = beat_q + 2'd1;
            if (beat_q == 2'd3) begin
                pop     = 1'b1;
                burst_d = 1'b0;
            end
        end else if (head_due) begin
            rvalid_d = 1'b1;
            raddr_d  = {ent_addr_q[rd_ptr_q], 5'b0};
            rdata_d  = ent_data_q[rd_ptr_q][0];
            beat_d   = 2'd1;
            burst_d  = 1'b1;
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
        ready_d = ((state_d == ST_IDLE) && (count_d < DEPTH_C)) || (state_d == ST_WRITE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wbeat_q  <= 2'd0;
            widx_q   <= '0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            burst_q  <= 1'b0;
            beat_q   <= 2'd0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            raddr_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wbeat_q  <= wbeat_d;
            widx_q   <= widx_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            burst_q  <= burst_d;
            beat_q   <= beat_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            raddr_q  <= raddr_d;
            rdata_q  <= rdata_d;
        end
    end

    // NOTE: storage arrays carry no reset; validity lives in the reset pointers/count.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_widx][mem_wbeat] <= bus.bmem_wdata;
    end

    // Snapshot the whole line at accept so later writes cannot change queued read data.
    always_ff @(posedge clk) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (ent_cnt_q[i] != '0) ent_cnt_q[i] <= ent_cnt_q[i] - CNT_W'(1);
        end
        if (push) begin
            ent_addr_q[wr_ptr_q] <= bus.bmem_addr[31:5];
            ent_data_q[wr_ptr_q] <= mem_q[addr_idx];
            ent_cnt_q[wr_ptr_q]  <= LAT_INIT;
        end
    end

    assign bus.bmem_ready  = ready_q;
    assign bus.bmem_rvalid = rvalid_q;
    assign bus.bmem_raddr  = raddr_q;
    assign bus.bmem_rdata  = rdata_q;
    assign bus.proto_err   = err_q;
endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder: stimulus pushes expected read beats into a
// scoreboard that a negedge monitor pops and compares whenever rvalid is high.
module tb_burst_mem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    burst_mem_responder_if bus();

    burst_mem_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        int          cyc;
    } beat_t;

    beat_t sb[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line word k for tag: {tag, 40'h0123456789, k}
    function automatic logic [63:0] pat(input logic [15:0] tag, input int k);
        return {tag, 40'h01_2345_6789, 8'(k)};
    endfunction

    always @(negedge clk) begin : monitor
        beat_t e;
        if (rst_n && bus.bmem_rvalid) begin
            if (sb.size() == 0) begin
                check("rvalid_unexpected", 64'(bus.bmem_rvalid), 64'd0);
            end else begin
                e = sb.pop_front();
                check("raddr", 64'(bus.bmem_raddr), 64'(e.addr));
                check("rdata", bus.bmem_rdata, e.data);
                if (e.cyc >= 0) check("beat_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (bus.bmem_ready !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        if (t == 50) check("ready_wait", 64'(bus.bmem_ready), 64'd1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        tick();
    endtask

    // delay < 0: timing not checked; otherwise beat k expected at issue cycle + delay + k.
    task automatic do_read(input logic [31:0] addr, input logic [15:0] tag,
                           input int nbeats, input int delay);
        wait_ready();
        bus.bmem_read = 1'b1;
        bus.bmem_addr = addr;
        for (int k = 0; k < nbeats; k++)
            sb.push_back('{{addr[31:5], 5'b0}, pat(tag, k), (delay < 0) ? -1 : cyc + delay + k});
        tick();
        bus.bmem_read = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [15:0] tag,
                            input int stall, input bit with_read);
        wait_ready();
        bus.bmem_write = 1'b1;
        bus.bmem_read  = with_read;
        bus.bmem_addr  = addr;
        bus.bmem_wdata = pat(tag, 0);
        tick();
        bus.bmem_read = 1'b0;
        bus.bmem_addr = 32'hFFFF_FFE0;
        if (with_read) check("proto_err_set", 64'(bus.proto_err), 64'd1);
        for (int k = 1; k < 4; k++) begin
            if (k == 2) begin
                for (int s = 0; s < stall; s++) begin
                    bus.bmem_write = 1'b0;
                    tick();
                    check("stall_ready", 64'(bus.bmem_ready), 64'd1);
                end
            end
            bus.bmem_write = 1'b1;
            bus.bmem_wdata = pat(tag, k);
            tick();
        end
        bus.bmem_write = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int c0;
        bus.bmem_read  = 1'b0;
        bus.bmem_write = 1'b0;
        bus.bmem_addr  = '0;
        bus.bmem_wdata = '0;

        // Reset state
        tick(3);
        check("rst_ready",  64'(bus.bmem_ready),  64'd0);
        check("rst_rvalid", 64'(bus.bmem_rvalid), 64'd0);
        check("rst_raddr",  64'(bus.bmem_raddr),  64'd0);
        check("rst_rdata",  bus.bmem_rdata,       64'd0);
        check("rst_err",    64'(bus.proto_err),   64'd0);
        rst_n = 1'b1;
        tick();
        check("ready_after_release", 64'(bus.bmem_ready), 64'd1);

        // 1: write line then read it back with minimum latency
        do_write(32'h0000_1000, 16'hA000, 0, 1'b0);
        do_read(32'h0000_1000, 16'hA000, 4, 4);
        wait_drain();

        // 2: four back-to-back reads fill the queue and return 16 contiguous beats
        do_write(32'h0000_0000, 16'hD000, 0, 1'b0);
        do_write(32'h0000_0020, 16'hD001, 0, 1'b0);
        do_write(32'h0000_0040, 16'hD002, 0, 1'b0);
        do_write(32'h0000_0060, 16'hD003, 0, 1'b0);
        tick(2);
        c0 = cyc;
        for (int i = 0; i < 4; i++)
            do_read(32'h0000_0000 + 32'(i * 32), 16'hD000 + 16'(i), 4, 4 + 3 * i);
        check("full_ready_c4", 64'(bus.bmem_ready), 64'd0);
        check("issue_backtoback", 64'(cyc), 64'(c0 + 4));
        tick(2);
        check("full_ready_c6", 64'(bus.bmem_ready), 64'd0);
        tick(2);
        check("ready_after_pop", 64'(bus.bmem_ready), 64'd1);
        wait_drain();

        // 3: read snapshot is taken at accept; 0x2000 aliases line index 0
        do_write(32'h0000_2000, 16'hB000, 0, 1'b0);
        do_read(32'h0000_2000, 16'hB000, 4, -1);
        do_write(32'h0000_2000, 16'hC000, 0, 1'b0);
        do_read(32'h0000_2000, 16'hC000, 4, -1);
        wait_drain();

        // 4: write with two stall cycles; 0x3000 aliases 0x1000 so both read back E*
        do_write(32'h0000_3000, 16'hE000, 2, 1'b0);
        do_read(32'h0000_3000, 16'hE000, 4, -1);
        do_read(32'h0000_1000, 16'hE000, 4, -1);
        wait_drain();

        // 5: read and write together -> write stored, read dropped, sticky error
        check("err_before", 64'(bus.proto_err), 64'd0);
        do_write(32'h0000_4000, 16'hF000, 0, 1'b1);
        tick(10);
        check("dropped_read_no_beats", 64'(sb.size()), 64'd0);
        do_read(32'h0000_4000, 16'hF000, 4, -1);
        wait_drain();
        check("err_sticky", 64'(bus.proto_err), 64'd1);

        // 6: reset during beat 1 aborts the burst; stored lines survive
        do_read(32'h0000_3000, 16'hE000, 1, 4);
        tick(4);
        #1 rst_n = 1'b0;
        #1;
        check("abort_rvalid", 64'(bus.bmem_rvalid), 64'd0);
        check("abort_ready",  64'(bus.bmem_ready),  64'd0);
        tick(2);
        rst_n = 1'b1;
        tick();
        check("ready_after_abort", 64'(bus.bmem_ready), 64'd1);
        check("err_cleared", 64'(bus.proto_err), 64'd0);
        tick(10);
        check("no_beats_after_abort", 64'(sb.size()), 64'd0);
        do_read(32'h0000_4000, 16'hF000, 4, 4);
        wait_drain();
        do_read(32'h0000_0020, 16'hD001, 4, -1);
        do_read(32'h0000_3000, 16'hE000, 4, -1);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
